// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the per-road countdown display.
// Durations are converted to BCD at elaboration; the segment decode is combinational.
package traffic_pkg;

  localparam int LIGHT_RED = 2;
  localparam int LIGHT_YEL = 1;
  localparam int LIGHT_GRN = 0;

  localparam int unsigned GREEN_S_DEF  = 40;
  localparam int unsigned YELLOW_S_DEF = 5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd, input logic blank);
    logic [6:0] seg;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = SEG_BLANK;
      endcase
    end
    return seg;
  endfunction

  function automatic logic [7:0] bin_to_bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  function automatic logic light_ok(input logic [2:0] light);
    return (light == 3'b001) || (light == 3'b010) || (light == 3'b100);
  endfunction

endpackage

// File: rtl/road_countdown.sv
// One road: loads the phase duration on a light change, then counts down in BCD to 00 and holds.
// Load one edge after the light change; outputs are decoded from registers only.
module road_countdown
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_S  = GREEN_S_DEF,
  parameter int unsigned YELLOW_S = YELLOW_S_DEF,
  parameter int unsigned RED_S    = GREEN_S_DEF + YELLOW_S_DEF
) (
  input  logic       clk_1Hz,
  input  logic       sys_rst_n,
  input  logic [2:0] light,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic [7:0] bcd
);

  localparam logic [7:0] GRN_BCD = bin_to_bcd(GREEN_S);
  localparam logic [7:0] YEL_BCD = bin_to_bcd(YELLOW_S);
  localparam logic [7:0] RED_BCD = bin_to_bcd(RED_S);

  logic [2:0] prev_q,  prev_d;
  logic [7:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic [7:0] dur;

  always_comb begin
    prev_d  = light;
    count_d = count_q;
    valid_d = valid_q;
    if (light[LIGHT_GRN])      dur = GRN_BCD;
    else if (light[LIGHT_YEL]) dur = YEL_BCD;
    else                       dur = RED_BCD;

    if (!light_ok(light)) begin
      count_d = 8'h00;
      valid_d = 1'b0;
    end else if (light != prev_q) begin
      count_d = dur;
      valid_d = 1'b1;
    end else if (count_q != 8'h00) begin
      // Ones digit borrows from tens; 00 is never reached from here, so no wrap to 99
      if (count_q[3:0] == 4'd0) count_d = {count_q[7:4] - 4'd1, 4'd9};
      else                      count_d = {count_q[7:4], count_q[3:0] - 4'd1};
    end
  end

  always_ff @(posedge clk_1Hz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_q  <= 3'b000;
      count_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign bcd      = count_q;
  assign seg_tens = bcd_to_seg7(count_q[7:4], !valid_q || (count_q[7:4] == 4'd0));
  assign seg_ones = bcd_to_seg7(count_q[3:0], !valid_q);

endmodule

// File: rtl/traffic_countdown.sv
// Two road countdowns plus a sticky fault for conflicting or illegal light buses.
// Fault registers one edge after the condition and clears only on reset.
module traffic_countdown
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_S  = GREEN_S_DEF,
  parameter int unsigned YELLOW_S = YELLOW_S_DEF,
  parameter int unsigned RED_S    = GREEN_S + YELLOW_S
) (
  input  logic       clk_1Hz,
  input  logic       sys_rst_n,
  input  logic [2:0] A_Light,
  input  logic [2:0] B_Light,
  output logic [6:0] a_seg_tens,
  output logic [6:0] a_seg_ones,
  output logic [6:0] b_seg_tens,
  output logic [6:0] b_seg_ones,
  output logic [7:0] a_bcd,
  output logic [7:0] b_bcd,
  output logic       fault
);

  if (GREEN_S < 1 || GREEN_S > 99 || YELLOW_S < 1 || YELLOW_S > 99 || RED_S > 99) begin : g_bad_duration
    $error("traffic_countdown: phase durations must fit in two BCD digits");
  end

  road_countdown #(.GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S), .RED_S(RED_S)) u_road_a (
    .clk_1Hz  (clk_1Hz),
    .sys_rst_n(sys_rst_n),
    .light    (A_Light),
    .seg_tens (a_seg_tens),
    .seg_ones (a_seg_ones),
    .bcd      (a_bcd)
  );

  road_countdown #(.GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S), .RED_S(RED_S)) u_road_b (
    .clk_1Hz  (clk_1Hz),
    .sys_rst_n(sys_rst_n),
    .light    (B_Light),
    .seg_tens (b_seg_tens),
    .seg_ones (b_seg_ones),
    .bcd      (b_bcd)
  );

  logic fault_q, fault_d;
  logic fault_cond;

  // At least one road must always be red
  assign fault_cond = !light_ok(A_Light) || !light_ok(B_Light) ||
                      (!A_Light[LIGHT_RED] && !B_Light[LIGHT_RED]);

  always_comb begin
    fault_d = fault_q | fault_cond;
  end

  always_ff @(posedge clk_1Hz or negedge sys_rst_n) begin
    if (!sys_rst_n) fault_q <= 1'b0;
    else            fault_q <= fault_d;
  end

  assign fault = fault_q;

endmodule

// File: tb/tb_traffic_countdown.sv
// Directed bench with a reference model feeding an expectation queue; each edge pops and compares.
module tb_traffic_countdown;

  logic       clk_1Hz   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [2:0] A_Light   = 3'b111;
  logic [2:0] B_Light   = 3'b010;
  logic [6:0] a_seg_tens, a_seg_ones, b_seg_tens, b_seg_ones;
  logic [7:0] a_bcd, b_bcd;
  logic       fault;

  traffic_countdown dut (
    .clk_1Hz   (clk_1Hz),
    .sys_rst_n (sys_rst_n),
    .A_Light   (A_Light),
    .B_Light   (B_Light),
    .a_seg_tens(a_seg_tens),
    .a_seg_ones(a_seg_ones),
    .b_seg_tens(b_seg_tens),
    .b_seg_ones(b_seg_ones),
    .a_bcd     (a_bcd),
    .b_bcd     (b_bcd),
    .fault     (fault)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  typedef struct {
    string       tag;
    logic [7:0]  a_bcd;
    logic [7:0]  b_bcd;
    logic [27:0] segs;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int         m_ca, m_cb;
  bit         m_va, m_vb, m_f;
  logic [2:0] m_pa, m_pb;
  logic [6:0] seg_tab [10];

  function automatic bit legal(input logic [2:0] l);
    return $countones(l) == 1;
  endfunction

  function automatic int dur_of(input logic [2:0] l);
    case (l)
      3'b001:  return 40;
      3'b010:  return 5;
      3'b100:  return 45;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] bcd_of(input int c);
    return 8'(((c / 10) * 16) + (c % 10));
  endfunction

  function automatic logic [13:0] segs_of(input int c, input bit v);
    logic [6:0] t, o;
    t = (!v || (c / 10) == 0) ? 7'h7F : seg_tab[c / 10];
    o = (!v) ? 7'h7F : seg_tab[c % 10];
    return {t, o};
  endfunction

  task automatic road_model(input logic [2:0] l, input int c, input bit v, input logic [2:0] p,
                            output int nc, output bit nv);
    nc = c;
    nv = v;
    if (!legal(l)) begin
      nc = 0;
      nv = 0;
    end else if (l != p) begin
      nc = dur_of(l);
      nv = 1;
    end else if (c > 0) begin
      nc = c - 1;
    end
  endtask

  task automatic model_reset();
    m_ca = 0; m_cb = 0; m_va = 0; m_vb = 0; m_f = 0;
    m_pa = 3'b000; m_pb = 3'b000;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_segs"}, {a_seg_tens, a_seg_ones, b_seg_tens, b_seg_ones}, 28'hFFF_FFFF);
    chk({tag, "_a_bcd"}, a_bcd, 8'h00);
    chk({tag, "_b_bcd"}, b_bcd, 8'h00);
    chk({tag, "_fault"}, fault, 1'b0);
  endtask

  // Called at a falling edge: drive, predict, wait one rising edge, compare, return at next falling edge
  task automatic step(input logic [2:0] a, input logic [2:0] b, input string tag);
    exp_t e;
    int   nca, ncb;
    bit   nva, nvb;
    A_Light = a;
    B_Light = b;
    road_model(a, m_ca, m_va, m_pa, nca, nva);
    road_model(b, m_cb, m_vb, m_pb, ncb, nvb);
    m_f  = m_f | !legal(a) | !legal(b) | (!a[2] && !b[2]);
    m_ca = nca; m_va = nva; m_pa = a;
    m_cb = ncb; m_vb = nvb; m_pb = b;
    e.tag   = tag;
    e.a_bcd = bcd_of(m_ca);
    e.b_bcd = bcd_of(m_cb);
    e.segs  = {segs_of(m_ca, m_va), segs_of(m_cb, m_vb)};
    e.fault = m_f;
    sb.push_back(e);
    @(posedge clk_1Hz);
    #1;
    e = sb.pop_front();
    chk({e.tag, "_a_bcd"}, a_bcd, e.a_bcd);
    chk({e.tag, "_b_bcd"}, b_bcd, e.b_bcd);
    chk({e.tag, "_segs"}, {a_seg_tens, a_seg_ones, b_seg_tens, b_seg_ones}, e.segs);
    chk({e.tag, "_fault"}, fault, e.fault);
    @(negedge clk_1Hz);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    model_reset();

    // Reset held with arbitrary (illegal) lights
    #12;
    check_reset("rst_hold");

    // Phase 1: A green, B red; first edge after release loads
    @(negedge clk_1Hz);
    sys_rst_n = 1'b1;
    step(3'b001, 3'b100, "load");
    chk("load_a_const", a_bcd, 8'h40);
    chk("load_b_const", b_bcd, 8'h45);
    for (int i = 2; i <= 40; i++) begin
      step(3'b001, 3'b100, "green");
      if (i == 32) begin
        chk("tens_blank_09", a_seg_tens, 7'h7F);
        chk("ones_9", a_seg_ones, 7'h10);
      end
    end
    chk("a_at_01", a_bcd, 8'h01);
    chk("b_at_06", b_bcd, 8'h06);
    step(3'b010, 3'b100, "to_yellow");
    chk("yellow_load", a_bcd, 8'h05);
    chk("b_keeps_counting", b_bcd, 8'h05);
    step(3'b010, 3'b100, "yellow");
    chk("fault_clear", fault, 1'b0);
    step(3'b001, 3'b010, "no_red");
    chk("fault_set", fault, 1'b1);
    step(3'b100, 3'b001, "legal_again");
    step(3'b100, 3'b001, "legal_again2");
    chk("fault_sticky", fault, 1'b1);

    // Phase 2: reset clears fault, then async reset mid-count
    @(negedge clk_1Hz);
    sys_rst_n = 1'b0;
    #1;
    check_reset("rst_phase2");
    model_reset();
    @(negedge clk_1Hz);
    sys_rst_n = 1'b1;
    for (int i = 1; i <= 18; i++) step(3'b001, 3'b100, "count");
    chk("a_at_23", a_bcd, 8'h23);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_reset("rst_async");
    model_reset();
    @(negedge clk_1Hz);
    sys_rst_n = 1'b1;
    step(3'b001, 3'b100, "reload");
    chk("reload_full", a_bcd, 8'h40);
    for (int i = 2; i <= 42; i++) step(3'b001, 3'b100, "overstay");
    chk("hold_00", a_bcd, 8'h00);
    chk("hold_00_ones", a_seg_ones, 7'h40);
    chk("hold_00_tens", a_seg_tens, 7'h7F);
    chk("b_at_04", b_bcd, 8'h04);

    step(3'b011, 3'b100, "illegal");
    chk("illegal_bcd", a_bcd, 8'h00);
    chk("illegal_blank", {a_seg_tens, a_seg_ones}, 14'h3FFF);
    chk("illegal_fault", fault, 1'b1);
    step(3'b100, 3'b100, "restore_red");
    chk("restore_load", a_bcd, 8'h45);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
